simt_stack_bank: RTL
====================

SIMT_STACK_BANK -- requirements
Module: simt_stack_bank

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 32, number of independent per-warp stacks (2^WIDBITS).
REQ-002 SHALL have parameter STACK_DEPTH, default 16 (SIMT_STACK_DEPTH), entries per warp stack, >=2.
REQ-003 SHALL have parameter PC_W, default 32 (XLEN), reconvergence PC width.
REQ-004 SHALL have parameter MASK_W, default 32, thread active-mask width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port op_valid_i  in  1  operation request valid.
REQ-008 SHALL have port op_ready_o  out  1  operation request accepted when high together with op_valid_i.
REQ-009 SHALL have port op_i  in  3  branch_op_t code; only BRA_PUSH, BRA_POP, BRA_FLUSH act.
REQ-010 SHALL have port op_wid_i  in  clog2(NUM_WARPS)  target warp.
REQ-011 SHALL have port push_pc_i  in  PC_W  PC stored by push.
REQ-012 SHALL have port push_mask_i  in  MASK_W  mask stored by push.
REQ-013 SHALL have port rsp_valid_o  out  1  pop response valid.
REQ-014 SHALL have port rsp_ready_i  in  1  pop response consumed.
REQ-015 SHALL have port rsp_wid_o / rsp_pc_o / rsp_mask_o  out  widths as above  popped entry.
REQ-016 SHALL have port rsp_underflow_o  out  1  response is from a pop on an empty stack.
REQ-017 SHALL have port empty_o  out  NUM_WARPS  bit w high when stack w holds zero entries.
REQ-018 SHALL have port err_o  out  32  sticky error word, bits per KIANA_SP_ERR_* codes.
REQ-019 SHALL have port err_clear_i  in  1  clears err_o.

Function
REQ-020 Per-warp pointer SHALL be clog2(STACK_DEPTH+1) bits, counting 0..STACK_DEPTH, never wrapping.
REQ-021 op_ready_o SHALL equal !rsp_valid_o || rsp_ready_i (combinational).
REQ-022 Accepted PUSH with ptr<STACK_DEPTH SHALL write {push_pc_i,push_mask_i} at index ptr and increment ptr on the same edge.
REQ-023 Accepted PUSH with ptr==STACK_DEPTH SHALL leave storage and ptr unchanged and set err_o bit 5 (SIMT_STACK_OVERFLOW).
REQ-024 Accepted POP with ptr>0 SHALL decrement ptr and, one cycle after acceptance, assert rsp_valid_o with entry ptr-1, rsp_underflow_o=0.
REQ-025 Accepted POP with ptr==0 SHALL leave ptr 0, set err_o bit 6 (SIMT_STACK_UNDERFLOW), and return a response with pc/mask 0, rsp_underflow_o=1.
REQ-026 Accepted FLUSH SHALL set ptr of op_wid_i to 0 with no response; other op codes SHALL be accepted as no-ops.
REQ-027 Response fields SHALL hold stable while rsp_valid_o && !rsp_ready_i; rsp_valid_o drops the cycle after rsp_ready_i unless a new POP is accepted the same cycle (back-to-back pops, one per cycle).
REQ-028 PUSH then POP on the same warp in consecutive cycles SHALL return the just-pushed entry (no read hazard).
REQ-029 err_clear_i SHALL zero err_o next edge; a new error on the same edge SHALL win (its bit set).
REQ-030 empty_o SHALL be combinational from pointers, updating the cycle after the changing operation.

Reset
REQ-031 rst_n low SHALL asynchronously clear all pointers, rsp_valid_o, rsp_wid_o, rsp_pc_o, rsp_mask_o, rsp_underflow_o, err_o; empty_o all ones.
REQ-032 Stack storage SHALL not be reset; reset mid-response SHALL discard the pending response.

Configuration
REQ-033 With KIANA_SIMT_STACK_ERR_EN defined, err_o and err_clear_i SHALL behave per REQ-023/025/029.
REQ-034 Without KIANA_SIMT_STACK_ERR_EN, err_o SHALL be constant 0, err_clear_i ignored; rsp_underflow_o and all other behaviour unchanged.

Verification
REQ-035 Push warp 3 PC 0x100 mask 0xF, PC 0x200 mask 0x3, pop twice with rsp_ready_i=1 -> responses 0x200/0x3 then 0x100/0xF, empty_o[3]=1.
REQ-036 17 pushes to warp 0 (depth 16) -> 17th dropped, err_o=0x20; 16 pops return entries 16..1 in order.
REQ-037 Pop on empty warp 5 -> rsp_underflow_o=1, pc/mask 0, err_o bit 6 set; err_clear_i -> err_o=0.
REQ-038 Pop with rsp_ready_i=0 for 4 cycles -> op_ready_o=0, response stable; ready high -> next POP accepted same cycle.
REQ-039 Push warps 1 and 2, FLUSH warp 1 -> empty_o[1]=1, empty_o[2]=0, warp 2 pop returns its entry.
REQ-040 Assert rst_n low while rsp_valid_o=1 -> rsp_valid_o=0, err_o=0, empty_o all ones immediately.

Source files
------------

// File: rtl/simt_stack_bank.sv
// Bank of per-warp SIMT reconvergence stacks: push/pop/flush by warp id, one op per cycle.
// Optional sticky error reporting is enabled by defining KIANA_SIMT_STACK_ERR_EN.
package simt_stack_pkg;
  typedef enum logic [2:0] {
    BRA_NOP   = 3'd0,
    BRA_PUSH  = 3'd1,
    BRA_POP   = 3'd2,
    BRA_FLUSH = 3'd3
  } branch_op_t;

  localparam int ERR_SIMT_STACK_OVERFLOW  = 5;
  localparam int ERR_SIMT_STACK_UNDERFLOW = 6;
endpackage

module simt_stack_bank
  import simt_stack_pkg::*;
#(
  parameter int NUM_WARPS   = 32,
  parameter int STACK_DEPTH = 16,
  parameter int PC_W        = 32,
  parameter int MASK_W      = 32,
  localparam int WID_W      = $clog2(NUM_WARPS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 op_valid_i,
  output logic                 op_ready_o,
  input  logic [2:0]           op_i,
  input  logic [WID_W-1:0]     op_wid_i,
  input  logic [PC_W-1:0]      push_pc_i,
  input  logic [MASK_W-1:0]    push_mask_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [WID_W-1:0]     rsp_wid_o,
  output logic [PC_W-1:0]      rsp_pc_o,
  output logic [MASK_W-1:0]    rsp_mask_o,
  output logic                 rsp_underflow_o,
  output logic [NUM_WARPS-1:0] empty_o,
  output logic [31:0]          err_o,
  input  logic                 err_clear_i
);

  localparam int PTR_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int ENT_W = PC_W + MASK_W;

  logic [PTR_W-1:0]  r_ptr [NUM_WARPS];
  logic [ENT_W-1:0]  r_mem [NUM_WARPS][STACK_DEPTH];

  logic              r_rsp_valid;
  logic [WID_W-1:0]  r_rsp_wid;
  logic [PC_W-1:0]   r_rsp_pc;
  logic [MASK_W-1:0] r_rsp_mask;
  logic              r_rsp_underflow;

  logic              w_accept, w_push, w_pop, w_flush;
  logic [PTR_W-1:0]  w_cur_ptr;
  logic              w_full, w_is_empty;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic [ENT_W-1:0]  w_rd_entry;

  // A held response blocks new ops only while the consumer is not taking it.
  assign op_ready_o = !r_rsp_valid || rsp_ready_i;
  assign w_accept   = op_valid_i && op_ready_o;
  assign w_push     = w_accept && (op_i == BRA_PUSH);
  assign w_pop      = w_accept && (op_i == BRA_POP);
  assign w_flush    = w_accept && (op_i == BRA_FLUSH);

  assign w_cur_ptr  = r_ptr[op_wid_i];
  assign w_full     = (w_cur_ptr == PTR_W'(STACK_DEPTH));
  assign w_is_empty = (w_cur_ptr == '0);
  assign w_wr_idx   = w_cur_ptr[IDX_W-1:0];
  assign w_rd_idx   = IDX_W'(w_cur_ptr - 1'b1);
  assign w_rd_entry = r_mem[op_wid_i][w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++) r_ptr[w] <= '0;
    end else if (w_push && !w_full) begin
      r_ptr[op_wid_i] <= w_cur_ptr + 1'b1;
    end else if (w_pop && !w_is_empty) begin
      r_ptr[op_wid_i] <= w_cur_ptr - 1'b1;
    end else if (w_flush) begin
      r_ptr[op_wid_i] <= '0;
    end
  end

  // NOTE: storage is deliberately not reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !w_full) r_mem[op_wid_i][w_wr_idx] <= {push_pc_i, push_mask_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid     <= 1'b0;
      r_rsp_wid       <= '0;
      r_rsp_pc        <= '0;
      r_rsp_mask      <= '0;
      r_rsp_underflow <= 1'b0;
    end else if (w_pop) begin
      r_rsp_valid     <= 1'b1;
      r_rsp_wid       <= op_wid_i;
      r_rsp_underflow <= w_is_empty;
      if (w_is_empty) {r_rsp_pc, r_rsp_mask} <= '0;
      else            {r_rsp_pc, r_rsp_mask} <= w_rd_entry;
    end else if (rsp_ready_i) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid_o     = r_rsp_valid;
  assign rsp_wid_o       = r_rsp_wid;
  assign rsp_pc_o        = r_rsp_pc;
  assign rsp_mask_o      = r_rsp_mask;
  assign rsp_underflow_o = r_rsp_underflow;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    empty_o = '0;
    for (int w = 0; w < NUM_WARPS; w++) empty_o[w] = (r_ptr[w] == '0);
  end

`ifdef KIANA_SIMT_STACK_ERR_EN
  logic [31:0] r_err;
  logic [31:0] w_err_new;

  always_comb begin
    w_err_new = '0;
    w_err_new[ERR_SIMT_STACK_OVERFLOW]  = w_push && w_full;
    w_err_new[ERR_SIMT_STACK_UNDERFLOW] = w_pop && w_is_empty;
  end

  // Clear and a same-edge new error are OR-ed so the new error survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= '0;
    else        r_err <= (err_clear_i ? 32'h0 : r_err) | w_err_new;
  end

  assign err_o = r_err;
`else
  // Error reporting compiled out; the clear input is folded away to a constant zero.
  assign err_o = {32{err_clear_i}} & 32'h0;
`endif

endmodule
